// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op-code constants,
// FSM state encoding and the legal-op check.
package alu_arbiter_pkg;

    // Widest op-code the legal-op check can examine.
    localparam int OP_MAXW = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arbState_t;

    // Callers zero-extend their op-code, so any set upper bit makes the op illegal.
    function automatic logic isLegalOp(input logic [OP_MAXW-1:0] op);
        logic legal;
        case (op)
            OP_MAXW'(OP_AND),
            OP_MAXW'(OP_OR),
            OP_MAXW'(OP_ADD),
            OP_MAXW'(OP_SUB),
            OP_MAXW'(OP_SLT): legal = 1'b1;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// pointer picks the winner (ptr = 0 favours requester 0).
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    output logic [1:0] grant
);

    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept in
// IDLE, sample the ALU result in EXEC, hold the response in RESP.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             CLK,
    input  logic             Reset_n,

    input  logic             ReqValid0,
    output logic             ReqReady0,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqB0,
    input  logic [OPW-1:0]   ReqOp0,

    input  logic             ReqValid1,
    output logic             ReqReady1,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB1,
    input  logic [OPW-1:0]   ReqOp1,

    output logic [WIDTH-1:0] ALUSrcA,
    output logic [WIDTH-1:0] ALUSrcB,
    output logic [OPW-1:0]   Op,
    input  logic [WIDTH-1:0] R,

    output logic             RspValid,
    input  logic             RspReady,
    output logic             RspId,
    output logic [WIDTH-1:0] RspData,
    output logic             RspErr,

    output logic             Busy,
    output logic [15:0]      OpCount
);

    arbState_t        state;
    arbState_t        stateNext;
    logic             ptrQ;
    logic [1:0]       grant;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [OPW-1:0]   opQ;
    logic             idQ;
    logic [WIDTH-1:0] rspDataQ;
    logic             rspErrQ;
    logic [15:0]      opCountQ;
    logic             opLegal;
    logic             rspFire;

    // Requests are only visible to the arbiter in IDLE, so later arrivals simply wait.
    rr_arb2 uArb (
        .valid0 (ReqValid0 && (state == IDLE)),
        .valid1 (ReqValid1 && (state == IDLE)),
        .ptr    (ptrQ),
        .grant  (grant)
    );

    // Gating with Reset_n keeps the ready outputs low for the whole reset pulse.
    assign ReqReady0 = grant[0] & Reset_n;
    assign ReqReady1 = grant[1] & Reset_n;

    assign opLegal = isLegalOp(OP_MAXW'(opQ));
    assign rspFire = (state == RESP) && RspReady;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grant != 2'b00) stateNext = EXEC;
            EXEC:    stateNext = RESP;
            RESP:    if (RspReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            ptrQ     <= 1'b0;
            aQ       <= '0;
            bQ       <= '0;
            opQ      <= '0;
            idQ      <= 1'b0;
            rspDataQ <= '0;
            rspErrQ  <= 1'b0;
            opCountQ <= '0;
        end else begin
            state <= stateNext;

            if (grant[1]) begin
                aQ  <= ReqA1;
                bQ  <= ReqB1;
                opQ <= ReqOp1;
                idQ <= 1'b1;
            end else if (grant[0]) begin
                aQ  <= ReqA0;
                bQ  <= ReqB0;
                opQ <= ReqOp0;
                idQ <= 1'b0;
            end

            // The pointer moves only on a grant and then favours the other requester.
            if (grant != 2'b00) begin
                ptrQ <= grant[0];
            end

            if (state == EXEC) begin
                rspDataQ <= opLegal ? R : '0;
                rspErrQ  <= ~opLegal;
            end

            if (rspFire) begin
                opCountQ <= opCountQ + 16'd1;
            end
        end
    end

    assign ALUSrcA  = aQ;
    assign ALUSrcB  = bQ;
    assign Op       = opQ;
    assign RspValid = (state == RESP);
    assign RspId    = idQ;
    assign RspData  = rspDataQ;
    assign RspErr   = rspErrQ;
    assign Busy     = (state != IDLE);
    assign OpCount  = opCountQ;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: plays the external ALU16b and compares
// every transaction against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
    logic        ReqReady0, ReqReady1;
    logic [15:0] ReqA0 = '0, ReqB0 = '0, ReqA1 = '0, ReqB1 = '0;
    logic [2:0]  ReqOp0 = '0, ReqOp1 = '0;
    logic [15:0] ALUSrcA, ALUSrcB, R;
    logic [2:0]  Op;
    logic        RspValid, RspId, RspErr, Busy;
    logic        RspReady = 1'b0;
    logic [15:0] RspData, OpCount;

    int nChecks = 0;
    int nFails  = 0;

    // Transaction-level model state.
    logic        pendValid [2];
    logic [15:0] pendA [2];
    logic [15:0] pendB [2];
    logic [2:0]  pendOp [2];
    int          lastGrant;
    logic [15:0] opCountModel;

    always #5 CLK = ~CLK;

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqOp0(ReqOp0),
        .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqOp1(ReqOp1),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Op(Op), .R(R),
        .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId), .RspData(RspData), .RspErr(RspErr),
        .Busy(Busy), .OpCount(OpCount)
    );

    // Stand-in for ALU16b; unsupported codes yield junk that the arbiter must suppress.
    function automatic logic [15:0] aluRef(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b010:  return a | b;
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign R = aluRef(ALUSrcA, ALUSrcB, Op);

    function automatic logic legalRef(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101) || (op == 3'b111);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReqs();
        ReqValid0 = pendValid[0]; ReqA0 = pendA[0]; ReqB0 = pendB[0]; ReqOp0 = pendOp[0];
        ReqValid1 = pendValid[1]; ReqA1 = pendA[1]; ReqB1 = pendB[1]; ReqOp1 = pendOp[1];
    endtask

    // Changes the operand/op lines of a requester whose operation is already in flight.
    task automatic scramble(input int id);
        if (id == 0) begin
            ReqA0 = 16'($urandom); ReqB0 = 16'($urandom); ReqOp0 = 3'($urandom);
        end else begin
            ReqA1 = 16'($urandom); ReqB1 = 16'($urandom); ReqOp1 = 3'($urandom);
        end
    endtask

    task automatic setReq(input int id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        pendValid[id] = 1'b1;
        pendA[id]     = a;
        pendB[id]     = b;
        pendOp[id]    = op;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rdy0"},  32'(ReqReady0), 32'(0));
        check({tag, "_rdy1"},  32'(ReqReady1), 32'(0));
        check({tag, "_srca"},  32'(ALUSrcA),   32'(0));
        check({tag, "_srcb"},  32'(ALUSrcB),   32'(0));
        check({tag, "_op"},    32'(Op),        32'(0));
        check({tag, "_valid"}, 32'(RspValid),  32'(0));
        check({tag, "_id"},    32'(RspId),     32'(0));
        check({tag, "_data"},  32'(RspData),   32'(0));
        check({tag, "_err"},   32'(RspErr),    32'(0));
        check({tag, "_busy"},  32'(Busy),      32'(0));
        check({tag, "_count"}, 32'(OpCount),   32'(0));
    endtask

    // Called just after a falling edge with the DUT idle; runs one full transaction.
    task automatic serveOne(input int respDelay);
        int          w;
        logic [15:0] ea, eb, ed;
        logic [2:0]  eo;
        logic        ee;
        applyReqs();
        #1;
        if (pendValid[0] && pendValid[1]) w = 1 - lastGrant;
        else w = pendValid[1] ? 1 : 0;
        check("accept_rdy0", 32'(ReqReady0), 32'(w == 0));
        check("accept_rdy1", 32'(ReqReady1), 32'(w == 1));
        check("accept_busy", 32'(Busy), 32'(0));
        ea = pendA[w]; eb = pendB[w]; eo = pendOp[w];
        ee = !legalRef(eo);
        ed = ee ? 16'h0000 : aluRef(ea, eb, eo);
        lastGrant    = w;
        pendValid[w] = 1'b0;

        @(negedge CLK);
        applyReqs();
        scramble(w);
        RspReady = (respDelay == 0);
        #1;
        check("exec_valid", 32'(RspValid),  32'(0));
        check("exec_busy",  32'(Busy),      32'(1));
        check("exec_rdy0",  32'(ReqReady0), 32'(0));
        check("exec_rdy1",  32'(ReqReady1), 32'(0));
        check("exec_srca",  32'(ALUSrcA),   32'(ea));
        check("exec_srcb",  32'(ALUSrcB),   32'(eb));
        check("exec_op",    32'(Op),        32'(eo));

        @(negedge CLK);
        scramble(w);
        #1;
        check("resp_valid", 32'(RspValid),  32'(1));
        check("resp_data",  32'(RspData),   32'(ed));
        check("resp_id",    32'(RspId),     32'(w));
        check("resp_err",   32'(RspErr),    32'(ee));
        check("resp_rdy0",  32'(ReqReady0), 32'(0));
        check("resp_rdy1",  32'(ReqReady1), 32'(0));

        for (int i = 0; i < respDelay; i++) begin
            @(negedge CLK);
            #1;
            check("hold_valid", 32'(RspValid),  32'(1));
            check("hold_data",  32'(RspData),   32'(ed));
            check("hold_id",    32'(RspId),     32'(w));
            check("hold_err",   32'(RspErr),    32'(ee));
            check("hold_busy",  32'(Busy),      32'(1));
            check("hold_rdy0",  32'(ReqReady0), 32'(0));
            check("hold_rdy1",  32'(ReqReady1), 32'(0));
            check("hold_srca",  32'(ALUSrcA),   32'(ea));
            check("hold_count", 32'(OpCount),   32'(opCountModel));
        end
        RspReady = 1'b1;

        @(negedge CLK);
        #1;
        opCountModel = opCountModel + 16'd1;
        check("done_valid", 32'(RspValid), 32'(0));
        check("done_count", 32'(OpCount),  32'(opCountModel));
    endtask

    task automatic doReset();
        @(negedge CLK);
        Reset_n = 1'b0;
        for (int i = 0; i < 2; i++) pendValid[i] = 1'b0;
        applyReqs();
        RspReady = 1'b0;
        #1;
        checkAllZero("reset");
        @(negedge CLK);
        Reset_n      = 1'b1;
        lastGrant    = 1;
        opCountModel = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            pendValid[i] = 1'b0; pendA[i] = '0; pendB[i] = '0; pendOp[i] = '0;
        end
        lastGrant    = 1;
        opCountModel = 16'h0000;
        #1;
        checkAllZero("por");
        doReset();

        // Single ADD from requester 0.
        setReq(0, 16'h0001, 16'h0001, 3'b100);
        serveOne(0);

        // Tie straight out of reset goes to requester 0, then requester 1 back-to-back.
        doReset();
        setReq(0, 16'hFFFF, 16'h8888, 3'b000);
        setReq(1, 16'hEEEE, 16'h1111, 3'b010);
        serveOne(0);
        serveOne(0);

        // Illegal op-code.
        setReq(1, 16'h1234, 16'h4321, 3'b011);
        serveOne(0);

        // Back-pressure for five cycles.
        setReq(1, 16'h1234, 16'h00FF, 3'b000);
        serveOne(5);

        // SLT and SUB corner values.
        setReq(0, 16'h8000, 16'h0001, 3'b111);
        serveOne(1);
        setReq(1, 16'h0000, 16'h0001, 3'b101);
        serveOne(0);

        // Reset in the middle of EXEC drops the operation.
        setReq(0, 16'h0005, 16'h0003, 3'b101);
        setReq(1, 16'h0007, 16'h0002, 3'b100);
        applyReqs();
        #1;
        check("midrst_accept", 32'(ReqReady0 | ReqReady1), 32'(1));
        @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        checkAllZero("midrst");
        @(negedge CLK);
        Reset_n      = 1'b1;
        lastGrant    = 1;
        opCountModel = 16'h0000;
        for (int i = 0; i < 2; i++) pendValid[i] = 1'b0;
        applyReqs();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check("midrst_noresp", 32'(RspValid), 32'(0));
            check("midrst_idle",   32'(Busy),     32'(0));
        end
        setReq(0, 16'h0010, 16'h0020, 3'b100);
        setReq(1, 16'h0030, 16'h0040, 3'b100);
        serveOne(0);
        serveOne(0);

        // Counter wrap: preload near the top instead of running 65k operations.
        force dut.opCountQ = 16'hFFFE;
        @(negedge CLK);
        release dut.opCountQ;
        opCountModel = 16'hFFFE;
        #1;
        check("wrap_preload", 32'(OpCount), 32'(opCountModel));
        setReq(0, 16'h00AA, 16'h0055, 3'b010);
        serveOne(0);
        setReq(1, 16'h0003, 16'h0004, 3'b100);
        serveOne(0);
        check("wrap_zero", 32'(OpCount), 32'(16'h0000));

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pendValid[id] && ($urandom_range(0, 2) != 0)) begin
                    setReq(id, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
                end
            end
            if (pendValid[0] || pendValid[1]) begin
                serveOne(int'($urandom_range(0, 2)));
            end else begin
                applyReqs();
                @(negedge CLK);
                #1;
                check("idle_busy", 32'(Busy), 32'(0));
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (pendValid[i]) serveOne(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
